// File: rtl/metropolis_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : metropolis_sequencer_if                                         |
// | Purpose  : Bundles the run-control and datapath-control signals of the     |
// |            metropolis sequencer.                                           |
// | Modports : master - node run control (drives start/iter_num/stop/shift_req)|
// |            slave  - the sequencer (drives slot id, pulses, coefficient)    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface metropolis_sequencer_if #(
   parameter int BASE_NUM = 4,
   parameter int BASE_LOG = $clog2(BASE_NUM)
);
   logic                start;
   logic [15:0]         iter_num;
   logic                stop;
   logic                shift_req;
   logic [BASE_LOG-1:0] base_id;
   logic                opt_run;
   logic                exp_init;
   logic                exp_run;
   logic                exp_fin;
   logic [16:0]         exp_recip;
   logic                exch_en;
   logic                distance_shift;
   logic                busy;
   logic                done;

   modport master (
      output start, iter_num, stop, shift_req,
      input  base_id, opt_run, exp_init, exp_run, exp_fin, exp_recip,
             exch_en, distance_shift, busy, done
   );

   modport slave (
      input  start, iter_num, stop, shift_req,
      output base_id, opt_run, exp_init, exp_run, exp_fin, exp_recip,
             exch_en, distance_shift, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/metropolis_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : metropolis_sequencer                                            |
// | Purpose  : Time-multiplexed controller stepping every base slot of a node  |
// |            through one Metropolis trial (opt advance, exp init, exp        |
// |            iterations with 1/(k+1) coefficients, exp finish), followed by  |
// |            an exchange sweep, repeated for a programmed iteration count.   |
// |            Also runs a standalone distance-shift sweep on request.         |
// | Ports    : clk   - clock                                                   |
// |            reset - asynchronous, active-low reset                          |
// |            bus   - slave modport: start/iter_num/stop/shift_req in;        |
// |                    base_id, control pulses, exp_recip, busy, done out      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module metropolis_sequencer #(
   parameter int BASE_NUM = 4,
   parameter int BASE_LOG = $clog2(BASE_NUM),
   parameter int EXP_LEN  = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   metropolis_sequencer_if.slave  bus
);

   localparam logic [BASE_LOG-1:0] c_LAST_BASE = BASE_LOG'(BASE_NUM - 1);
   localparam logic [3:0]          c_LAST_K    = 4'(EXP_LEN - 1);

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_OPT   = 4'd1,
      S_INIT  = 4'd2,
      S_RUN   = 4'd3,
      S_FIN   = 4'd4,
      S_NEXT  = 4'd5,
      S_EXCH  = 4'd6,
      S_SHIFT = 4'd7,
      S_DONE  = 4'd8
   } state_t;

   state_t              state_q, state_d;
   logic [BASE_LOG-1:0] base_id_q, base_id_d;
   logic [3:0]          k_q, k_d;
   logic [15:0]         iter_left_q, iter_left_d;
   logic [16:0]         w_recip;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         base_id_q   <= '0;
         k_q         <= '0;
         iter_left_q <= '0;
      end else begin
         state_q     <= state_d;
         base_id_q   <= base_id_d;
         k_q         <= k_d;
         iter_left_q <= iter_left_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      base_id_d   = base_id_q;
      k_d         = k_q;
      iter_left_d = iter_left_q;
      unique case (state_q)
         S_IDLE: begin
            // start has priority; a coincident shift_req is simply dropped
            if (bus.start) begin
               iter_left_d = bus.iter_num;
               base_id_d   = '0;
               state_d     = (bus.iter_num == 16'd0) ? S_DONE : S_OPT;
            end else if (bus.shift_req) begin
               base_id_d = '0;
               state_d   = S_SHIFT;
            end
         end
         S_OPT:  state_d = S_INIT;
         S_INIT: begin
            k_d     = '0;
            state_d = S_RUN;
         end
         S_RUN: begin
            k_d = k_q + 4'd1;
            if (k_q == c_LAST_K) begin
               state_d = S_FIN;
            end
         end
         // stop ends the run after the current slot's decision, skipping exchange
         S_FIN:  state_d = bus.stop ? S_DONE : S_NEXT;
         S_NEXT: begin
            if (base_id_q == c_LAST_BASE) begin
               base_id_d = '0;
               state_d   = S_EXCH;
            end else begin
               base_id_d = base_id_q + 1'b1;
               state_d   = S_OPT;
            end
         end
         S_EXCH: begin
            if (base_id_q == c_LAST_BASE) begin
               base_id_d = '0;
               if (iter_left_q != 16'd0) begin
                  iter_left_d = iter_left_q - 16'd1;
               end
               state_d = (iter_left_q <= 16'd1) ? S_DONE : S_OPT;
            end else begin
               base_id_d = base_id_q + 1'b1;
            end
         end
         S_SHIFT: begin
            if (base_id_q == c_LAST_BASE) begin
               base_id_d = '0;
               state_d   = S_DONE;
            end else begin
               base_id_d = base_id_q + 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Taylor coefficients 1/(k+1) in unsigned Q1.16, truncated
   always_comb begin
      w_recip = 17'd0;
      unique case (k_q)
         4'd0:    w_recip = 17'd65536;
         4'd1:    w_recip = 17'd32768;
         4'd2:    w_recip = 17'd21845;
         4'd3:    w_recip = 17'd16384;
         4'd4:    w_recip = 17'd13107;
         4'd5:    w_recip = 17'd10922;
         4'd6:    w_recip = 17'd9362;
         4'd7:    w_recip = 17'd8192;
         4'd8:    w_recip = 17'd7281;
         4'd9:    w_recip = 17'd6553;
         4'd10:   w_recip = 17'd5957;
         4'd11:   w_recip = 17'd5461;
         4'd12:   w_recip = 17'd5041;
         4'd13:   w_recip = 17'd4681;
         4'd14:   w_recip = 17'd4369;
         4'd15:   w_recip = 17'd4096;
         default: w_recip = 17'd0;
      endcase
   end

   // Moore decode: every output derives from registered state only
   assign bus.base_id        = base_id_q;
   assign bus.opt_run        = (state_q == S_OPT);
   assign bus.exp_init       = (state_q == S_INIT);
   assign bus.exp_run        = (state_q == S_RUN);
   assign bus.exp_fin        = (state_q == S_FIN);
   assign bus.exp_recip      = (state_q == S_RUN) ? w_recip : 17'd0;
   assign bus.exch_en        = (state_q == S_EXCH);
   assign bus.distance_shift = (state_q == S_SHIFT);
   assign bus.busy           = (state_q != S_IDLE);
   assign bus.done           = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_metropolis_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_metropolis_sequencer                                         |
// | Purpose  : Scoreboard bench for metropolis_sequencer. A reference model    |
// |            expands each command into its expected pulse timeline; a       |
// |            monitor pops and compares whenever the DUT shows any output.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_metropolis_sequencer;
   localparam int BASE_NUM = 4;
   localparam int BASE_LOG = 2;
   localparam int EXP_LEN  = 8;
   localparam int BIG      = 1 << 30;

   // pulse vector order: {opt, init, run, fin, exch, shift, done}
   localparam logic [6:0] P_OPT   = 7'b1000000;
   localparam logic [6:0] P_INIT  = 7'b0100000;
   localparam logic [6:0] P_RUN   = 7'b0010000;
   localparam logic [6:0] P_FIN   = 7'b0001000;
   localparam logic [6:0] P_EXCH  = 7'b0000100;
   localparam logic [6:0] P_SHIFT = 7'b0000010;
   localparam logic [6:0] P_DONE  = 7'b0000001;

   typedef struct {
      int         cyc;
      int         bid;
      logic [6:0] p;
      int         recip;
   } ev_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   metropolis_sequencer_if #(.BASE_NUM(BASE_NUM), .BASE_LOG(BASE_LOG)) bus();

   metropolis_sequencer #(
      .BASE_NUM (BASE_NUM),
      .BASE_LOG (BASE_LOG),
      .EXP_LEN  (EXP_LEN)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   ev_t exp_q[$];
   int  ncnt     = 0;
   int  base     = 0;
   int  n_checks = 0;
   int  n_err    = 0;
   int  m_rel;
   ev_t m_e;

   always @(posedge clk) ncnt <= ncnt + 1;

   function automatic logic [6:0] pulses();
      return {bus.opt_run, bus.exp_init, bus.exp_run, bus.exp_fin,
              bus.exch_en, bus.distance_shift, bus.done};
   endfunction

   function automatic bit all_zero();
      return (pulses() == 7'd0) && (bus.exp_recip == 17'd0) &&
             (bus.base_id == '0) && (bus.busy == 1'b0);
   endfunction

   // Monitor: any visible output must match the head of the expected queue
   always @(negedge clk) begin
      if (reset && (pulses() != 7'd0 || bus.exp_recip != 17'd0)) begin
         m_rel = ncnt - base;
         n_checks++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_output cycle=%0d pulses=%b base_id=%0d recip=%0d required=no output",
                     m_rel, pulses(), bus.base_id, bus.exp_recip);
         end else begin
            m_e = exp_q.pop_front();
            if (m_rel != m_e.cyc || int'(bus.base_id) != m_e.bid || pulses() != m_e.p ||
                int'(bus.exp_recip) != m_e.recip || bus.busy !== 1'b1) begin
               n_err++;
               $display("FAIL event got cycle=%0d pulses=%b base_id=%0d recip=%0d busy=%b required cycle=%0d pulses=%b base_id=%0d recip=%0d busy=1",
                        m_rel, pulses(), bus.base_id, bus.exp_recip, bus.busy,
                        m_e.cyc, m_e.p, m_e.bid, m_e.recip);
            end
         end
      end
   end

   task automatic push(input int c, input int b, input logic [6:0] p, input int r);
      ev_t e;
      e.cyc = c; e.bid = b; e.p = p; e.recip = r;
      exp_q.push_back(e);
   endtask

   // Reference model: slot = OPT, INIT, EXP_LEN RUN, FIN, NEXT; then exchange sweep
   task automatic model_run(input int n_iter, input int stop_cyc);
      int c;
      c = 1;
      if (n_iter == 0) begin
         push(1, 0, P_DONE, 0);
         return;
      end
      for (int it = 0; it < n_iter; it++) begin
         for (int s = 0; s < BASE_NUM; s++) begin
            push(c, s, P_OPT, 0);
            push(c + 1, s, P_INIT, 0);
            for (int k = 0; k < EXP_LEN; k++) push(c + 2 + k, s, P_RUN, 65536 / (k + 1));
            push(c + 2 + EXP_LEN, s, P_FIN, 0);
            if (c + 2 + EXP_LEN >= stop_cyc) begin
               push(c + 3 + EXP_LEN, s, P_DONE, 0);
               return;
            end
            c += EXP_LEN + 4;
         end
         for (int s = 0; s < BASE_NUM; s++) push(c + s, s, P_EXCH, 0);
         c += BASE_NUM;
      end
      push(c, 0, P_DONE, 0);
   endtask

   task automatic model_shift();
      for (int s = 0; s < BASE_NUM; s++) push(1 + s, s, P_SHIFT, 0);
      push(BASE_NUM + 1, 0, P_DONE, 0);
   endtask

   task automatic do_cmd(input bit st, input bit sh, input int n_iter,
                         input int stop_cyc, input int budget);
      bit seen;
      seen = 1'b0;
      @(negedge clk); #1;
      exp_q.delete();
      if (st) model_run(n_iter, stop_cyc);
      else if (sh) model_shift();
      base          = ncnt;
      bus.start     = st;
      bus.shift_req = sh;
      bus.iter_num  = 16'(n_iter);
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk); #1;
         if (ncnt - base >= stop_cyc) bus.stop = 1'b1;
         if (bus.done) begin
            seen          = 1'b1;
            bus.start     = 1'b0;
            bus.shift_req = 1'b0;
            bus.stop      = 1'b0;
         end else begin
            // noise while busy must be ignored
            bus.start     = 1'($urandom_range(0, 1));
            bus.shift_req = 1'($urandom_range(0, 1));
            bus.iter_num  = 16'($urandom);
         end
      end
      n_checks++;
      if (!seen) begin
         n_err++;
         $display("FAIL done_timeout got=no done within %0d cycles required=done", budget);
         bus.start = 1'b0; bus.shift_req = 1'b0; bus.stop = 1'b0;
      end
      @(negedge clk); #1;
      n_checks++;
      if (bus.busy !== 1'b0) begin
         n_err++;
         $display("FAIL busy_after_done got=%b required=0", bus.busy);
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL missing_events got=%0d outstanding required=0", exp_q.size());
      end
   endtask

   initial begin
      int r, n, sc;
      bus.start = 1'b0; bus.shift_req = 1'b0; bus.stop = 1'b0; bus.iter_num = 16'd0;

      // Reset held: inputs toggle, outputs must stay at zero
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); #1;
         n_checks++;
         if (!all_zero()) begin
            n_err++;
            $display("FAIL reset_hold got pulses=%b base_id=%0d recip=%0d busy=%b required all 0",
                     pulses(), bus.base_id, bus.exp_recip, bus.busy);
         end
         bus.start = 1'($urandom_range(0, 1)); bus.shift_req = 1'($urandom_range(0, 1));
         bus.stop = 1'($urandom_range(0, 1)); bus.iter_num = 16'($urandom);
      end
      bus.start = 1'b0; bus.shift_req = 1'b0; bus.stop = 1'b0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      n_checks++;
      if (!all_zero()) begin
         n_err++;
         $display("FAIL idle_after_reset got busy=%b pulses=%b required all 0", bus.busy, pulses());
      end

      do_cmd(1'b1, 1'b0, 1, BIG, 100);   // single iteration, done at 53
      do_cmd(1'b1, 1'b0, 3, BIG, 300);   // three iterations, done at 157
      do_cmd(1'b1, 1'b0, 2, 18, 300);    // stop during slot 1 RUN
      do_cmd(1'b1, 1'b0, 0, BIG, 20);    // zero iterations
      do_cmd(1'b1, 1'b1, 1, BIG, 100);   // start beats shift_req
      do_cmd(1'b0, 1'b1, 0, BIG, 20);    // shift sweep

      // Reset in the middle of RUN aborts without done
      @(negedge clk); #1;
      exp_q.delete();
      model_run(1, BIG);
      base = ncnt;
      bus.start = 1'b1; bus.iter_num = 16'd1;
      for (int i = 0; i < 20 && (ncnt - base) < 6; i++) begin
         @(negedge clk); #1;
         bus.start = 1'b0;
      end
      reset = 1'b0;
      #1;
      exp_q.delete();
      n_checks++;
      if (!all_zero()) begin
         n_err++;
         $display("FAIL async_reset got pulses=%b base_id=%0d recip=%0d busy=%b required all 0",
                  pulses(), bus.base_id, bus.exp_recip, bus.busy);
      end
      repeat (3) @(negedge clk);
      #1;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      n_checks++;
      if (bus.busy !== 1'b0) begin
         n_err++;
         $display("FAIL no_restart_after_reset got busy=%b required=0", bus.busy);
      end
      do_cmd(1'b1, 1'b0, 1, BIG, 100);   // fresh run reproduces single-iteration timing

      // Randomized commands
      for (int t = 0; t < 12; t++) begin
         r = $urandom_range(0, 3);
         if (r == 0) begin
            do_cmd(1'b0, 1'b1, 0, BIG, 20);
         end else if (r == 1) begin
            do_cmd(1'b1, 1'($urandom_range(0, 1)), 0, BIG, 20);
         end else begin
            n  = $urandom_range(1, 3);
            sc = ($urandom_range(0, 1) == 0) ? BIG : $urandom_range(1, 52 * n);
            do_cmd(1'b1, 1'($urandom_range(0, 1)), n, sc, 52 * n + 20);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
